// File: rtl/lsf_segment_aligner.sv
// Matches inner/middle/outer LSF segments to pending sector-logic candidates by muid
// and emits one aligned bundle per candidate, in SLC arrival order.
module lsf_segment_aligner #(
  parameter int DEPTH         = 8,
  parameter int TIMEOUT       = 400,
  parameter int MUID_W        = 8,
  parameter int MUID_LSB      = 0,
  parameter int CNT_W         = 16,
  parameter int SF2PTCALC_LEN = 32
) (
  input  logic                     clock,
  input  logic                     resetbar,
  input  logic [MUID_W-1:0]        i_slc_muid,
  input  logic                     i_slc_we,
  input  logic [SF2PTCALC_LEN-1:0] i_seg_inn,
  input  logic [SF2PTCALC_LEN-1:0] i_seg_mid,
  input  logic [SF2PTCALC_LEN-1:0] i_seg_out,
  input  logic                     i_seg_inn_we,
  input  logic                     i_seg_mid_we,
  input  logic                     i_seg_out_we,
  output logic [MUID_W-1:0]        o_muid,
  output logic [SF2PTCALC_LEN-1:0] o_seg_inn,
  output logic [SF2PTCALC_LEN-1:0] o_seg_mid,
  output logic [SF2PTCALC_LEN-1:0] o_seg_out,
  output logic [2:0]               o_seg_mask,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CNT_W-1:0]         o_slc_drop_cnt,
  output logic [CNT_W-1:0]         o_seg_drop_cnt,
  output logic [CNT_W-1:0]         o_timeout_cnt
);

  // Output handshake (valid/ready): a bundle transfers on every clock edge where
  // o_valid and i_ready are both high; while o_valid is high and i_ready is low,
  // every output holds its value; o_valid never drops without a transfer.

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  logic                     ent_vld  [DEPTH];
  logic [MUID_W-1:0]        ent_muid [DEPTH];
  logic [AGE_W-1:0]         ent_age  [DEPTH];
  logic [2:0]               ent_mask [DEPTH];
  logic [SF2PTCALC_LEN-1:0] ent_seg  [DEPTH][3];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [SF2PTCALC_LEN-1:0] seg_in  [3];
  logic [2:0]               seg_we;
  logic [2:0]               hit;
  logic [AW-1:0]            hit_idx [3];
  logic [2:0]               store;
  logic [2:0]               seg_drop;
  logic [1:0]               n_seg_drop;
  logic [AW-1:0]            idx;
  logic                     head_done, pop, push, slc_drop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    seg_in[0] = i_seg_inn;
    seg_in[1] = i_seg_mid;
    seg_in[2] = i_seg_out;
    seg_we    = {i_seg_out_we, i_seg_mid_we, i_seg_inn_we};
  end

  // Search from head so that the first hit is the oldest matching candidate.
  always_comb begin
    idx = '0;
    for (int s = 0; s < 3; s++) begin
      hit[s]     = 1'b0;
      hit_idx[s] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + AW'(i);
        if (!hit[s] && ent_vld[idx] &&
            ent_muid[idx] == seg_in[s][MUID_LSB +: MUID_W]) begin
          hit[s]     = 1'b1;
          hit_idx[s] = idx;
        end
      end
    end
  end

  always_comb begin
    head_done = ent_vld[head] &&
                (ent_mask[head] == 3'b111 || ent_age[head] >= AGE_W'(TIMEOUT));
    pop       = head_done && (!o_valid || i_ready);
    push      = i_slc_we && (count != CW'(DEPTH));
    slc_drop  = i_slc_we && !push;
    for (int s = 0; s < 3; s++) begin
      // A segment for the entry leaving this cycle has nowhere to go: count it as dropped.
      store[s]    = seg_we[s] && hit[s] && !ent_mask[hit_idx[s]][s] &&
                    !(pop && hit_idx[s] == head);
      seg_drop[s] = seg_we[s] && !store[s];
    end
    n_seg_drop = {1'b0, seg_drop[0]} + {1'b0, seg_drop[1]} + {1'b0, seg_drop[2]};
  end

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_muid[i] <= '0;
        ent_age[i]  <= '0;
        ent_mask[i] <= '0;
        for (int s = 0; s < 3; s++) ent_seg[i][s] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && ent_age[i] != AGE_W'(TIMEOUT)) ent_age[i] <= ent_age[i] + 1'b1;
      end
      for (int s = 0; s < 3; s++) begin
        if (store[s]) begin
          ent_seg[hit_idx[s]][s]  <= seg_in[s];
          ent_mask[hit_idx[s]][s] <= 1'b1;
        end
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // The tail slot is never valid while count < DEPTH, so no store can collide here.
      if (push) begin
        ent_vld[tail]  <= 1'b1;
        ent_muid[tail] <= i_slc_muid;
        ent_age[tail]  <= '0;
        ent_mask[tail] <= '0;
        for (int s = 0; s < 3; s++) ent_seg[tail][s] <= '0;
        tail <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      o_valid    <= 1'b0;
      o_muid     <= '0;
      o_seg_inn  <= '0;
      o_seg_mid  <= '0;
      o_seg_out  <= '0;
      o_seg_mask <= '0;
    end else if (pop) begin
      o_valid    <= 1'b1;
      o_muid     <= ent_muid[head];
      o_seg_mask <= ent_mask[head];
      o_seg_inn  <= ent_mask[head][0] ? ent_seg[head][0] : '0;
      o_seg_mid  <= ent_mask[head][1] ? ent_seg[head][1] : '0;
      o_seg_out  <= ent_mask[head][2] ? ent_seg[head][2] : '0;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      o_slc_drop_cnt <= '0;
      o_seg_drop_cnt <= '0;
      o_timeout_cnt  <= '0;
    end else begin
      if (slc_drop) o_slc_drop_cnt <= sat_add(o_slc_drop_cnt, 2'd1);
      if (n_seg_drop != 2'd0) o_seg_drop_cnt <= sat_add(o_seg_drop_cnt, n_seg_drop);
      if (pop && ent_mask[head] != 3'b111) o_timeout_cnt <= sat_add(o_timeout_cnt, 2'd1);
    end
  end

endmodule

// File: tb/tb_lsf_segment_aligner.sv
// Directed bench for lsf_segment_aligner: completion, timeout, full queue, drops,
// backpressure and asynchronous reset, all with hand-computed expectations.
module tb_lsf_segment_aligner;

  localparam int MUID_W = 8;
  localparam int CNT_W  = 16;
  localparam int SEG_W  = 32;

  logic              clock = 1'b0;
  logic              resetbar;
  logic [MUID_W-1:0] i_slc_muid;
  logic              i_slc_we;
  logic [SEG_W-1:0]  i_seg_inn, i_seg_mid, i_seg_out;
  logic              i_seg_inn_we, i_seg_mid_we, i_seg_out_we;
  logic [MUID_W-1:0] o_muid;
  logic [SEG_W-1:0]  o_seg_inn, o_seg_mid, o_seg_out;
  logic [2:0]        o_seg_mask;
  logic              o_valid;
  logic              i_ready;
  logic [CNT_W-1:0]  o_slc_drop_cnt, o_seg_drop_cnt, o_timeout_cnt;

  int total = 0;
  int bad   = 0;
  int exp_slc_drop = 0, exp_seg_drop = 0, exp_to = 0;
  logic [MUID_W-1:0] exp_q[$];

  lsf_segment_aligner #(.DEPTH(8), .TIMEOUT(400), .MUID_W(MUID_W), .MUID_LSB(0),
                        .CNT_W(CNT_W), .SF2PTCALC_LEN(SEG_W)) dut (
    .clock(clock), .resetbar(resetbar),
    .i_slc_muid(i_slc_muid), .i_slc_we(i_slc_we),
    .i_seg_inn(i_seg_inn), .i_seg_mid(i_seg_mid), .i_seg_out(i_seg_out),
    .i_seg_inn_we(i_seg_inn_we), .i_seg_mid_we(i_seg_mid_we), .i_seg_out_we(i_seg_out_we),
    .o_muid(o_muid), .o_seg_inn(o_seg_inn), .o_seg_mid(o_seg_mid), .o_seg_out(o_seg_out),
    .o_seg_mask(o_seg_mask), .o_valid(o_valid), .i_ready(i_ready),
    .o_slc_drop_cnt(o_slc_drop_cnt), .o_seg_drop_cnt(o_seg_drop_cnt),
    .o_timeout_cnt(o_timeout_cnt)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_slc_drop"}, 64'(o_slc_drop_cnt), 64'(exp_slc_drop));
    chk({tag, "_seg_drop"}, 64'(o_seg_drop_cnt), 64'(exp_seg_drop));
    chk({tag, "_timeout"},  64'(o_timeout_cnt),  64'(exp_to));
  endtask

  function automatic logic [SEG_W-1:0] mk_seg(input logic [23:0] tag, input logic [7:0] muid);
    return {tag, muid};
  endfunction

  // driver tasks: inputs change 1ns after a rising edge, outputs are checked there too
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cyc(input logic slc_we, input logic [7:0] muid, input logic [2:0] we,
                     input logic [SEG_W-1:0] si, input logic [SEG_W-1:0] sm,
                     input logic [SEG_W-1:0] so);
    i_slc_we = slc_we; i_slc_muid = muid;
    i_seg_inn_we = we[0]; i_seg_mid_we = we[1]; i_seg_out_we = we[2];
    i_seg_inn = si; i_seg_mid = sm; i_seg_out = so;
    step();
    i_slc_we = 1'b0; i_seg_inn_we = 1'b0; i_seg_mid_we = 1'b0; i_seg_out_we = 1'b0;
  endtask

  initial begin : stim
    logic [SEG_W-1:0] a_inn, b_inn, sega, segb, segc;
    int got;
    bit seen;

    resetbar = 1'b0; i_ready = 1'b1;
    i_slc_we = 1'b0; i_slc_muid = '0;
    i_seg_inn = '0; i_seg_mid = '0; i_seg_out = '0;
    i_seg_inn_we = 1'b0; i_seg_mid_we = 1'b0; i_seg_out_we = 1'b0;
    idle(3);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_muid", 64'(o_muid), 64'd0);
    chk("rst_mask", 64'(o_seg_mask), 64'd0);
    chk("rst_seg_inn", 64'(o_seg_inn), 64'd0);
    chk_cnts("rst");
    resetbar = 1'b1;
    idle(2);

    // 1: complete candidate; SLC at edge 0, segments at edges 10/20/30
    sega = mk_seg(24'h111111, 8'd5); segb = mk_seg(24'h222222, 8'd5); segc = mk_seg(24'h333333, 8'd5);
    cyc(1'b1, 8'd5, 3'b000, '0, '0, '0);
    idle(9); cyc(1'b0, 8'd0, 3'b001, sega, '0, '0);
    idle(9); cyc(1'b0, 8'd0, 3'b010, '0, segb, '0);
    idle(9); cyc(1'b0, 8'd0, 3'b100, '0, '0, segc);
    chk("t1_valid_early", 64'(o_valid), 64'd0);
    step();
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_muid", 64'(o_muid), 64'd5);
    chk("t1_mask", 64'(o_seg_mask), 64'h7);
    chk("t1_inn", 64'(o_seg_inn), 64'(sega));
    chk("t1_mid", 64'(o_seg_mid), 64'(segb));
    chk("t1_out", 64'(o_seg_out), 64'(segc));
    chk_cnts("t1");
    step();
    chk("t1_one_cycle", 64'(o_valid), 64'd0);

    // 4: unmatched, duplicate, same-cycle allocate
    cyc(1'b0, 8'd0, 3'b001, mk_seg(24'hABCDEF, 8'd77), '0, '0);
    cyc(1'b1, 8'd5, 3'b000, '0, '0, '0);
    a_inn = mk_seg(24'hA0A0A0, 8'd5); b_inn = mk_seg(24'hB0B0B0, 8'd5);
    cyc(1'b0, 8'd0, 3'b001, a_inn, '0, '0);
    cyc(1'b0, 8'd0, 3'b001, b_inn, '0, '0);
    cyc(1'b1, 8'd3, 3'b001, mk_seg(24'hC0C0C0, 8'd3), '0, '0);
    exp_seg_drop = 3;
    chk("t4_seg_drop", 64'(o_seg_drop_cnt), 64'(exp_seg_drop));
    cyc(1'b0, 8'd0, 3'b110, '0, mk_seg(24'h0D0D0D, 8'd5), mk_seg(24'h0E0E0E, 8'd5));
    step();
    chk("t4_valid5", 64'(o_valid), 64'd1);
    chk("t4_muid5", 64'(o_muid), 64'd5);
    chk("t4_first_wins", 64'(o_seg_inn), 64'(a_inn));
    cyc(1'b0, 8'd0, 3'b111, mk_seg(24'h313131, 8'd3), mk_seg(24'h323232, 8'd3),
        mk_seg(24'h333333, 8'd3));
    step();
    chk("t4_valid3", 64'(o_valid), 64'd1);
    chk("t4_muid3", 64'(o_muid), 64'd3);
    chk("t4_mask3", 64'(o_seg_mask), 64'h7);
    step();
    chk_cnts("t4");

    // 5: backpressure and ordering
    i_ready = 1'b0;
    cyc(1'b1, 8'd10, 3'b000, '0, '0, '0);
    cyc(1'b1, 8'd11, 3'b000, '0, '0, '0);
    sega = mk_seg(24'hAAAA01, 8'd10);
    cyc(1'b0, 8'd0, 3'b111, sega, mk_seg(24'hAAAA02, 8'd10), mk_seg(24'hAAAA03, 8'd10));
    cyc(1'b0, 8'd0, 3'b111, mk_seg(24'hBBBB01, 8'd11), mk_seg(24'hBBBB02, 8'd11),
        mk_seg(24'hBBBB03, 8'd11));
    for (int k = 0; k < 20; k++) begin
      chk("t5_hold", {o_valid, o_muid, o_seg_inn, o_seg_mask},
          {1'b1, 8'd10, sega, 3'h7});
      step();
    end
    i_ready = 1'b1;
    step();
    chk("t5_b_valid", 64'(o_valid), 64'd1);
    chk("t5_b_muid", 64'(o_muid), 64'd11);
    step();
    chk("t5_no_dup", 64'(o_valid), 64'd0);

    // 2: timeout with only the mid segment; allocation at edge 0, load at edge 401
    segb = mk_seg(24'h999999, 8'd9);
    cyc(1'b1, 8'd9, 3'b000, '0, '0, '0);
    cyc(1'b0, 8'd0, 3'b010, '0, segb, '0);
    seen = 1'b0;
    for (int k = 2; k <= 400; k++) begin
      if (o_valid) seen = 1'b1;
      step();
    end
    if (o_valid) seen = 1'b1;
    chk("t2_not_early", 64'(seen), 64'd0);
    step();
    exp_to = 1;
    chk("t2_valid", 64'(o_valid), 64'd1);
    chk("t2_muid", 64'(o_muid), 64'd9);
    chk("t2_mask", 64'(o_seg_mask), 64'h2);
    chk("t2_inn_zero", 64'(o_seg_inn), 64'd0);
    chk("t2_out_zero", 64'(o_seg_out), 64'd0);
    chk("t2_mid", 64'(o_seg_mid), 64'(segb));
    chk_cnts("t2");
    step();

    // 3: full queue, then a push in the same cycle as the first pop at count=8
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 8'(20 + k), 3'b000, '0, '0, '0);
      if (k < 8) exp_q.push_back(8'(20 + k));
    end
    exp_slc_drop = 1;
    chk("t3_slc_drop9", 64'(o_slc_drop_cnt), 64'(exp_slc_drop));
    idle(392);
    chk("t3_not_yet", 64'(o_valid), 64'd0);
    cyc(1'b1, 8'd99, 3'b000, '0, '0, '0);
    exp_slc_drop = 2;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) begin
        got++;
        if (exp_q.size() == 0) chk("t3_extra", 64'(o_muid), 64'hFFFF);
        else chk("t3_order", {o_muid, o_seg_mask}, {exp_q.pop_front(), 3'b000});
      end
      step();
    end
    exp_to = 1 + 8;
    chk("t3_count", 64'(got), 64'd8);
    chk_cnts("t3");

    // 6: reset mid-operation with o_valid=1 and three candidates pending
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(40 + k), 3'b000, '0, '0, '0);
    cyc(1'b0, 8'd0, 3'b111, mk_seg(24'h404040, 8'd40), mk_seg(24'h414141, 8'd40),
        mk_seg(24'h424242, 8'd40));
    step();
    chk("t6_valid_before", 64'(o_valid), 64'd1);
    #2 resetbar = 1'b0;
    #1;
    exp_slc_drop = 0; exp_seg_drop = 0; exp_to = 0;
    chk("t6_valid_async", 64'(o_valid), 64'd0);
    chk_cnts("t6");
    idle(2);
    resetbar = 1'b1;
    i_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 450; k++) begin
      if (o_valid) seen = 1'b1;
      step();
    end
    chk("t6_nothing_after", 64'(seen), 64'd0);
    cyc(1'b1, 8'd50, 3'b000, '0, '0, '0);
    cyc(1'b0, 8'd0, 3'b111, mk_seg(24'h505050, 8'd50), mk_seg(24'h515151, 8'd50),
        mk_seg(24'h525252, 8'd50));
    step();
    chk("t6_new_valid", 64'(o_valid), 64'd1);
    chk("t6_new_muid", 64'(o_muid), 64'd50);
    chk_cnts("t6_end");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
